// File: rtl/fb_port_arbiter.sv
// Two-requester arbiter onto one shared framebuffer port, with in-order read-response routing.
// Latency: commands pass through combinationally (0 cycles); read data returns 1 cycle after s_rvalid.
// Backpressure: s_ready stalls the winner; reads hold off while MAX_OUT reads are outstanding; writes never wait on that.
// Build option: define FB_ARB_FIXED_PRIO_EN for fixed m0-first priority (default is round-robin).

// Generic synchronous FIFO with asynchronous clear; DEPTH must be a power of two.
module fb_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

module fb_port_arbiter #(
  parameter int AW      = 24,
  parameter int DW      = 16,
  parameter int MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          s_req,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_ready,
  input  logic          s_rvalid,
  input  logic [DW-1:0] s_rdata,
  output logic          err
);
  logic elig0;
  logic elig1;
  logic win_id;
  logic win_vld;
  logic xfer;
  logic tag_push;
  logic tag_pop;
  logic tag_full;
  logic tag_empty;
  logic tag_id;

  // Reads need a free tag slot; writes never wait on it. A full FIFO blocks reads even if it pops this cycle.
  assign elig0   = m0_req && (m0_we || !tag_full);
  assign elig1   = m1_req && (m1_we || !tag_full);
  assign win_vld = (elig0 || elig1) && !reset;
  assign xfer    = win_vld && s_ready;

`ifdef FB_ARB_FIXED_PRIO_EN
  // Display scan always wins when it can go.
  always_comb begin
    win_id = 1'b0;
    if (!elig0 && elig1) win_id = 1'b1;
  end
`else
  logic last_grant;

  // On a tie the requester that did not win last time goes; otherwise the only eligible one.
  always_comb begin
    win_id = 1'b0;
    if (elig0 && elig1) win_id = !last_grant;
    else if (elig1)     win_id = 1'b1;
  end

  // Remember who completed the last transfer; reset value 1 hands the first tie to m0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last_grant <= 1'b1;
    else if (xfer) last_grant <= win_id;
  end
`endif

  // Forward the winner's command; everything is held at zero while in reset.
  always_comb begin
    s_req   = win_vld;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (!reset) begin
      s_we    = win_id ? m1_we    : m0_we;
      s_addr  = win_id ? m1_addr  : m0_addr;
      s_wdata = win_id ? m1_wdata : m0_wdata;
    end
  end

  assign m0_gnt   = xfer && !win_id;
  assign m1_gnt   = xfer && win_id;
  assign tag_push = xfer && !s_we;
  assign tag_pop  = s_rvalid;

  fb_fifo #(
    .W     (1),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (tag_push),
    .push_dat (win_id),
    .pop      (tag_pop),
    .pop_dat  (tag_id),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // Route each response to the requester at the head of the tag FIFO; orphan responses raise sticky err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      m0_rvalid <= s_rvalid && !tag_empty && !tag_id;
      m1_rvalid <= s_rvalid && !tag_empty && tag_id;
      if (s_rvalid && !tag_empty && !tag_id) m0_rdata <= s_rdata;
      if (s_rvalid && !tag_empty && tag_id)  m1_rdata <= s_rdata;
      if (s_rvalid && tag_empty)             err      <= 1'b1;
    end
  end
endmodule
